cell_plotter: RTL and testbench

//  Downstream of the life simulation stage: accepts cell-change events (cell x, y, colour)
//  and expands each into a square block of VGA pixels, driving the 160x120 vga_adapter
//  (x/y/colour/plot) one pixel per clock. A small FIFO absorbs back-to-back events while
//  a block is still being painted; in_ready provides backpressure to the simulation stage.

---
 rtl/cell_plotter_if.sv | 24 ++
 rtl/cell_plotter.sv | 143 ++++++++++++++
 tb/tb_cell_plotter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cell_plotter_if.sv
// Event-in / pixel-out bundle for cell_plotter.
// The master side is the event source; the slave side is the plotter.
interface cell_plotter_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [7:0] in_y;
    logic [2:0] in_color;
    logic [7:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    modport master (
        output in_valid, in_x, in_y, in_color,
        input  in_ready, vga_x, vga_y, vga_colour, vga_plot, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, in_color,
        output in_ready, vga_x, vga_y, vga_colour, vga_plot, busy
    );
endinterface

// File: rtl/cell_plotter.sv
// Expands cell-change events into square pixel blocks for a 160x120 vga_adapter, one pixel per clock.
// Optional macro CELL_PLOTTER_GRID_LINES_EN paints the top row and left column of every block blue.
module cell_plotter #(
    parameter int GRID_DIM   = 4,
    parameter int CELL_SHIFT = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int X_ORG      = 0,
    parameter int Y_ORG      = 0
) (
    input logic           clock,
    input logic           reset,
    cell_plotter_if.slave bus
);
    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [7:0] GRID_LIM = 8'(GRID_DIM);

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] col;
    } event_t;

    typedef enum logic {IDLE, PLOT} state_t;

    event_t          mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count;
    logic            full, empty, push, pop;
    event_t          head, in_evt;
    logic            head_ok;

    state_t          state_q, state_d;
    event_t          cur_q, cur_d;
    logic [CELL_SHIFT-1:0] sx_q, sx_d, sy_q, sy_d;
    logic            last_px;
    logic [7:0]      pix_x, pix_y;
    logic [2:0]      pix_col;

    logic [7:0]      vga_x_q, vga_x_d;
    logic [7:0]      vga_y_q, vga_y_d;
    logic [2:0]      vga_colour_q, vga_colour_d;
    logic            vga_plot_q, vga_plot_d;

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_comb begin
        count   = wr_ptr_q - rd_ptr_q;
        full    = count[AW];
        empty   = (count == '0);
        push    = bus.in_valid && !full;
        head    = mem_q[rd_ptr_q[AW-1:0]];
        head_ok = (head.x < GRID_LIM) && (head.y < GRID_LIM);
        in_evt  = '{x: bus.in_x, y: bus.in_y, col: bus.in_color};
        last_px = (&sx_q) && (&sy_q);
        pix_x   = 8'(X_ORG) + (cur_q.x << CELL_SHIFT) + 8'(sx_q);
        pix_y   = 8'(Y_ORG) + (cur_q.y << CELL_SHIFT) + 8'(sy_q);
`ifdef CELL_PLOTTER_GRID_LINES_EN
        pix_col = (sx_q == '0 || sy_q == '0) ? 3'b001 : cur_q.col;
`else
        pix_col = cur_q.col;
`endif
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        pop          = 1'b0;
        vga_plot_d   = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    cur_d = head;
                    sx_d  = '0;
                    sy_d  = '0;
                    if (head_ok) state_d = PLOT;
                end
            end
            PLOT: begin
                vga_plot_d   = 1'b1;
                vga_x_d      = pix_x;
                vga_y_d      = pix_y;
                vga_colour_d = pix_col;
                sx_d         = sx_q + 1'b1;
                if (&sx_q) sy_d = sy_q + 1'b1;
                // An out-of-range head is left for IDLE to discard, so only in-range heads chain here.
                if (last_px) begin
                    if (!empty && head_ok) begin
                        pop   = 1'b1;
                        cur_d = head;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_evt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= IDLE;
            cur_q        <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            cur_q        <= cur_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign bus.in_ready   = !full;
    assign bus.busy       = !empty || (state_q != IDLE);
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
endmodule

// File: tb/tb_cell_plotter.sv
// Scoreboard bench for cell_plotter: accepted events queue their expected pixels,
// and a negedge monitor checks every vga_plot pulse against the queue head.
module tb_cell_plotter;
    logic clock = 1'b0;
    logic reset = 1'b1;

    cell_plotter_if bus();

    cell_plotter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    logic [18:0] exp_q[$];
    int compared    = 0;
    int mismatched  = 0;
    int pulse_count = 0;
    int cur_run     = 0;
    int last_run    = 0;

    // Monitor: one comparison per plotted pixel; a reset flushes whatever was still expected.
    always @(negedge clock) begin
        logic [18:0] exp_px;
        if (reset) begin
            exp_q.delete();
            cur_run = 0;
        end else if (bus.vga_plot) begin
            pulse_count++;
            cur_run++;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_plot: got x=%0d y=%0d c=%0d, required no pulse",
                         bus.vga_x, bus.vga_y, bus.vga_colour);
            end else begin
                exp_px = exp_q.pop_front();
                if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== exp_px) begin
                    mismatched++;
                    $display("[TB] FAIL pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                             bus.vga_x, bus.vga_y, bus.vga_colour,
                             exp_px[18:11], exp_px[10:3], exp_px[2:0]);
                end
            end
        end else begin
            if (cur_run != 0) last_run = cur_run;
            cur_run = 0;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // Hand-derived pixel list for one 8x8 block on a 4x4 grid at origin (0,0).
    task automatic pushExpected(input logic [7:0] x, input logic [7:0] y, input logic [2:0] col);
        logic [7:0] px, py;
        logic [2:0] pc;
        if (x < 8'd4 && y < 8'd4) begin
            for (int sy = 0; sy < 8; sy++) begin
                for (int sx = 0; sx < 8; sx++) begin
                    px = 8'((x * 8) + sx);
                    py = 8'((y * 8) + sy);
`ifdef CELL_PLOTTER_GRID_LINES_EN
                    pc = (sx == 0 || sy == 0) ? 3'b001 : col;
`else
                    pc = col;
`endif
                    exp_q.push_back({px, py, pc});
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the edge on which the event transferred.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [2:0] col);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_color = col;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                @(posedge clock);
                #1;
                pushExpected(x, y, col);
                done = 1;
            end else begin
                @(posedge clock);
                #1;
            end
        end
        if (!done) checkOutput("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            if (!bus.busy && !bus.vga_plot) done = 1;
        end
        if (!done) checkOutput({name, "_idle_timeout"}, 0, 1);
        @(posedge clock);
        #1;
    endtask

    int base;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_color = '0;

        // Test 1: reset values, latency and a single block
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_vga_x", bus.vga_x, 0);
        checkOutput("rst_vga_y", bus.vga_y, 0);
        checkOutput("rst_colour", bus.vga_colour, 0);
        checkOutput("rst_plot", bus.vga_plot, 0);
        checkOutput("rst_busy", bus.busy, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        checkOutput("rst_in_ready", bus.in_ready, 1);

        base = pulse_count;
        applyStimulus(8'd1, 8'd2, 3'b111);
        @(negedge clock);
        checkOutput("t1_lat_e0", bus.vga_plot, 0);
        @(negedge clock);
        checkOutput("t1_lat_e1", bus.vga_plot, 0);
        @(negedge clock);
        checkOutput("t1_lat_e2", bus.vga_plot, 1);
        @(posedge clock);
        #1;
        waitIdle("t1");
        checkOutput("t1_pulses", pulse_count - base, 64);
        checkOutput("t1_plot_low", bus.vga_plot, 0);
        checkOutput("t1_busy_low", bus.busy, 0);

        // Test 2: five back-to-back events, backpressure and gapless painting
        base = pulse_count;
        applyStimulus(8'd0, 8'd0, 3'b001);
        applyStimulus(8'd1, 8'd0, 3'b010);
        applyStimulus(8'd2, 8'd1, 3'b011);
        applyStimulus(8'd3, 8'd3, 3'b100);
        applyStimulus(8'd0, 8'd3, 3'b101);
        checkOutput("t2_in_ready_full", bus.in_ready, 0);
        waitIdle("t2");
        checkOutput("t2_pulses", pulse_count - base, 320);
        checkOutput("t2_run", last_run, 320);

        // Test 3: out-of-range event is dropped, next one paints
        base = pulse_count;
        applyStimulus(8'd4, 8'd0, 3'b111);
        applyStimulus(8'd0, 8'd0, 3'b000);
        waitIdle("t3");
        checkOutput("t3_pulses", pulse_count - base, 64);

        // Test 4: reset in the middle of a block
        base = pulse_count;
        applyStimulus(8'd2, 8'd1, 3'b101);
        applyStimulus(8'd3, 8'd3, 3'b010);
        for (int i = 0; i < 200 && (pulse_count - base) < 20; i++) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("t4_vga_x", bus.vga_x, 0);
        checkOutput("t4_vga_y", bus.vga_y, 0);
        checkOutput("t4_colour", bus.vga_colour, 0);
        checkOutput("t4_plot", bus.vga_plot, 0);
        checkOutput("t4_busy", bus.busy, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        checkOutput("t4_in_ready", bus.in_ready, 1);
        base = pulse_count;
        repeat (100) @(posedge clock);
        #1;
        checkOutput("t4_no_pulses", pulse_count - base, 0);
        checkOutput("t4_busy_after", bus.busy, 0);

        // Test 5: push coincides with the chaining pop while two entries are held
        base = pulse_count;
        applyStimulus(8'd0, 8'd1, 3'b110);
        applyStimulus(8'd1, 8'd1, 3'b011);
        applyStimulus(8'd2, 8'd2, 3'b101);
        repeat (62) @(posedge clock);
        #1;
        applyStimulus(8'd3, 8'd0, 3'b001);
        applyStimulus(8'd1, 8'd3, 3'b100);
        checkOutput("t5_ready_at3", bus.in_ready, 1);
        applyStimulus(8'd2, 8'd0, 3'b010);
        checkOutput("t5_ready_at4", bus.in_ready, 0);
        waitIdle("t5");
        checkOutput("t5_pulses", pulse_count - base, 384);

        // Test 6: single cell at the origin (grid-line colouring when enabled)
        base = pulse_count;
        applyStimulus(8'd0, 8'd0, 3'b111);
        waitIdle("t6");
        checkOutput("t6_pulses", pulse_count - base, 64);
        checkOutput("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
